// File: rtl/vector_cfg_loader_if.sv
// vector_cfg_loader_if
//   Bundles the element stream and the lane-wise configuration write port
//   of the ping-pong vector buffer.
//   master : the loader (stream sink, cfg requester)
//   slave  : the environment (stream source, cfg responder)
//   Stream : s_valid, s_ready, s_data, s_last
//   Cfg    : cfg_valid, cfg_write, cfg_rready, cfg_addr, cfg_wdata, cfg_ready
interface vector_cfg_loader_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLELISM = 4,
    parameter int ADDR_WIDTH  = 10
);
    logic                              s_valid;
    logic                              s_ready;
    logic [DATA_WIDTH-1:0]             s_data;
    logic                              s_last;

    logic [PARALLELISM-1:0]            cfg_valid;
    logic [PARALLELISM-1:0]            cfg_write;
    logic [PARALLELISM-1:0]            cfg_rready;
    logic [PARALLELISM*ADDR_WIDTH-1:0] cfg_addr;
    logic [PARALLELISM*DATA_WIDTH-1:0] cfg_wdata;
    logic [PARALLELISM-1:0]            cfg_ready;

    modport master (
        input  s_valid, s_data, s_last,
        output s_ready,
        output cfg_valid, cfg_write, cfg_rready, cfg_addr, cfg_wdata,
        input  cfg_ready
    );

    modport slave (
        output s_valid, s_data, s_last,
        input  s_ready,
        input  cfg_valid, cfg_write, cfg_rready, cfg_addr, cfg_wdata,
        output cfg_ready
    );
endinterface

// File: rtl/vector_cfg_loader.sv
// vector_cfg_loader
//   Packs a valid/ready stream of vector elements into PARALLELISM-wide lane
//   writes on the configuration port of the ping-pong vector buffer.
//   Element k lands in lane k % PARALLELISM, row k / PARALLELISM.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      one-cycle load request (accepted in IDLE only)
//   length     element count, sampled on accepted start
//   bus        stream sink + cfg write master (vector_cfg_loader_if.master)
//   cfg_en     load in progress (FILL or ISSUE)
//   busy       not IDLE
//   done       one-cycle completion pulse
//   err        sticky error, cleared by the next accepted start
// PARALLELISM must be a power of two (lane index is taken from count bits).
module vector_cfg_loader #(
    parameter int LENGTH      = 1024,
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLELISM = 4,
    parameter int ADDR_WIDTH  = $clog2(LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    vector_cfg_loader_if.master   bus,
    output logic                  cfg_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int LANE_W = (PARALLELISM > 1) ? $clog2(PARALLELISM) : 1;
    localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH+1)'(LENGTH);

    typedef enum logic [1:0] {IDLE, FILL, ISSUE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH:0]    len_q,   len_d;
    logic [ADDR_WIDTH:0]    cnt_q,   cnt_d;
    logic [ADDR_WIDTH-1:0]  row_q,   row_d;
    logic [PARALLELISM-1:0] pend_q,  pend_d;
    logic [DATA_WIDTH-1:0]  pack_q [PARALLELISM];
    logic [DATA_WIDTH-1:0]  pack_d [PARALLELISM];
    logic                   err_q,   err_d;

    logic [LANE_W-1:0]      lane;
    logic [ADDR_WIDTH:0]    cnt_inc;

    logic                              s_ready;
    logic [PARALLELISM-1:0]            cfg_valid;
    logic [PARALLELISM*ADDR_WIDTH-1:0] cfg_addr;
    logic [PARALLELISM*DATA_WIDTH-1:0] cfg_wdata;

    assign lane    = cnt_q[LANE_W-1:0];
    assign cnt_inc = cnt_q + (ADDR_WIDTH+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            pend_q  <= '0;
            pack_q  <= '{default: '0};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            pend_q  <= pend_d;
            pack_q  <= pack_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        pend_d    = pend_q;
        pack_d    = pack_q;
        err_d     = err_q;
        s_ready   = 1'b0;
        cfg_valid = '0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        cfg_en    = 1'b0;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d  = length;
                    cnt_d  = '0;
                    row_d  = '0;
                    pend_d = '0;
                    err_d  = (length > LEN_MAX);
                    if (length == '0 || length > LEN_MAX) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            FILL: begin
                s_ready = 1'b1;
                cfg_en  = 1'b1;
                if (bus.s_valid) begin
                    pack_d[lane] = bus.s_data;
                    pend_d[lane] = 1'b1;
                    cnt_d        = cnt_inc;
                    // s_last must coincide exactly with the final element;
                    // it is only checked, never used to end the load.
                    if (bus.s_last != (cnt_inc == len_q)) begin
                        err_d = 1'b1;
                    end
                    if (lane == LANE_W'(PARALLELISM-1) || cnt_inc == len_q) begin
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE: begin
                cfg_en    = 1'b1;
                cfg_valid = pend_q;
                // Non-pending lanes drive zero address/data.
                for (int unsigned i = 0; i < PARALLELISM; i++) begin
                    if (pend_q[i]) begin
                        cfg_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = row_q;
                        cfg_wdata[i*DATA_WIDTH +: DATA_WIDTH] = pack_q[i];
                    end
                end
                pend_d = pend_q & ~bus.cfg_ready;
                if (pend_d == '0) begin
                    if (cnt_q == len_q) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + ADDR_WIDTH'(1);
                        state_d = FILL;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign err            = err_q;
    assign bus.s_ready    = s_ready;
    assign bus.cfg_valid  = cfg_valid;
    assign bus.cfg_write  = cfg_valid;
    assign bus.cfg_rready = '0;
    assign bus.cfg_addr   = cfg_addr;
    assign bus.cfg_wdata  = cfg_wdata;
endmodule

// File: tb/tb_vector_cfg_loader.sv
// tb_vector_cfg_loader
//   Directed bench for vector_cfg_loader with P=4, LENGTH=1024, 32-bit data.
//   Each load streams elements 1..N, records every accepted lane write into
//   mem[row*4+lane] and keeps a per-cycle trace of the cfg port.
module tb_vector_cfg_loader;
    localparam int LEN = 1024;
    localparam int DW  = 32;
    localparam int P   = 4;
    localparam int AW  = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   length;
    logic          cfg_en, busy, done, err;

    vector_cfg_loader_if #(.DATA_WIDTH(DW), .PARALLELISM(P), .ADDR_WIDTH(AW)) bus ();

    vector_cfg_loader #(
        .LENGTH(LEN), .DATA_WIDTH(DW), .PARALLELISM(P), .ADDR_WIDTH(AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .length (length),
        .bus    (bus),
        .cfg_en (cfg_en),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int             mem [64];
    int             wr_cnt, done_cnt, tr_n;
    logic [3:0]     tr_valid [64];
    logic [3:0]     tr_write [64];
    logic           tr_sready[64];
    logic           tr_cfgen [64];
    logic [39:0]    tr_addr  [64];
    logic [127:0]   tr_wdata [64];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_issue();
        for (int i = 0; i < tr_n; i++) begin
            if (tr_valid[i] != 4'h0) return i;
        end
        return 0;
    endfunction

    // Runs one load: start with len, stream 1..len, s_last on element index
    // last_at. cfg_ready is stall_pat for the first `stall` issue cycles,
    // then all ones. restart_at pulses an extra start at that loop cycle.
    // rst_on_issue raises rst in the first issue cycle and ends the run.
    task automatic run_load(input int len, input int last_at, input int stall,
                            input logic [3:0] stall_pat, input int restart_at,
                            input bit rst_on_issue);
        int idx = 0;
        int issue_cyc = 0;
        int cyc = 0;
        bit fire;
        bit quit = 1'b0;
        int row;
        tr_n = 0;
        wr_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 64; k++) mem[k] = 0;

        bus.s_valid = 1'b0;
        start  = 1'b1;
        length = (AW+1)'(len);
        @(posedge clk); #1;
        start = 1'b0;

        while (!quit) begin
            bus.s_valid   = (idx < len);
            bus.s_data    = DW'(idx + 1);
            bus.s_last    = (idx == last_at);
            start         = (cyc == restart_at);
            length        = (cyc == restart_at) ? (AW+1)'(8) : (AW+1)'(len);
            bus.cfg_ready = (bus.cfg_valid != 4'h0 && issue_cyc < stall) ? stall_pat : 4'hF;

            @(negedge clk);
            fire = bus.s_valid && bus.s_ready;
            if (tr_n < 64) begin
                tr_valid[tr_n]  = bus.cfg_valid;
                tr_write[tr_n]  = bus.cfg_write;
                tr_sready[tr_n] = bus.s_ready;
                tr_cfgen[tr_n]  = cfg_en;
                tr_addr[tr_n]   = bus.cfg_addr;
                tr_wdata[tr_n]  = bus.cfg_wdata;
                tr_n++;
            end
            for (int i = 0; i < P; i++) begin
                if (bus.cfg_valid[i] && bus.cfg_ready[i]) begin
                    row = int'(bus.cfg_addr[i*AW +: AW]);
                    if (row < 16) mem[row*P + i] = int'(bus.cfg_wdata[i*DW +: DW]);
                    wr_cnt++;
                end
            end
            if (bus.cfg_valid != 4'h0) issue_cyc++;
            if (done) begin
                done_cnt++;
                quit = 1'b1;
            end
            if (rst_on_issue && bus.cfg_valid != 4'h0) begin
                rst  = 1'b1;
                quit = 1'b1;
            end

            @(posedge clk); #1;
            if (fire) idx++;
            cyc++;
            if (!quit && cyc >= 200) begin
                check("load_timeout", done_cnt, 1);
                quit = 1'b1;
            end
        end
        bus.s_valid   = 1'b0;
        bus.s_last    = 1'b0;
        bus.cfg_ready = 4'hF;
        start         = 1'b0;
    endtask

    initial begin
        int j;
        rst = 1'b1;
        start = 1'b0;
        length = '0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.s_last = 1'b0;
        bus.cfg_ready = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {busy, done, err, cfg_en, bus.s_ready}, 5'b0);
        check("reset_cfg", {bus.cfg_valid, bus.cfg_write, bus.cfg_rready}, 12'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full beats, length 8
        run_load(8, 7, 0, 4'h0, -1, 1'b0);
        for (int k = 0; k < 8; k++) check($sformatf("full_mem%0d", k), mem[k], k + 1);
        check("full_wr_cnt", wr_cnt, 8);
        check("full_done_cnt", done_cnt, 1);
        check("full_err", err, 1'b0);
        check("full_busy_after", busy, 1'b0);
        check("full_fill_sready", tr_sready[0], 1'b1);
        check("full_fill_cfgen", tr_cfgen[0], 1'b1);
        check("full_issue_idx", first_issue(), 4);
        check("full_beat0_valid", tr_valid[4], 4'hF);
        check("full_beat0_write", tr_write[4], 4'hF);
        check("full_beat0_addr", tr_addr[4], 40'h0);
        check("full_beat0_data", tr_wdata[4], {32'd4, 32'd3, 32'd2, 32'd1});
        check("full_beat1_addr", tr_addr[9], {10'd1, 10'd1, 10'd1, 10'd1});
        check("full_beat1_data", tr_wdata[9], {32'd8, 32'd7, 32'd6, 32'd5});
        check("full_rready", bus.cfg_rready, 4'h0);

        // Partial last beat, length 6
        run_load(6, 5, 0, 4'h0, -1, 1'b0);
        check("part_wr_cnt", wr_cnt, 6);
        check("part_mem4", mem[4], 5);
        check("part_mem5", mem[5], 6);
        check("part_valid", tr_valid[7], 4'b0011);
        check("part_addr", tr_addr[7], {10'd0, 10'd0, 10'd1, 10'd1});
        check("part_data", tr_wdata[7], {32'd0, 32'd0, 32'd6, 32'd5});
        check("part_err", err, 1'b0);

        // Staggered acceptance, cfg_ready = 1011 for three issue cycles
        run_load(8, 7, 3, 4'b1011, -1, 1'b0);
        j = first_issue();
        check("stag_valid0", tr_valid[j], 4'hF);
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("stag_valid%0d", k), tr_valid[j+k], 4'b0100);
            check($sformatf("stag_addr2_%0d", k), tr_addr[j+k][29:20], 10'd0);
            check($sformatf("stag_data2_%0d", k), tr_wdata[j+k][95:64], 32'd3);
        end
        check("stag_sready_hold", {tr_sready[j], tr_sready[j+1], tr_sready[j+2], tr_sready[j+3]}, 4'b0);
        check("stag_next_fill", tr_sready[j+4], 1'b1);
        for (int k = 0; k < 8; k++) check($sformatf("stag_mem%0d", k), mem[k], k + 1);
        check("stag_wr_cnt", wr_cnt, 8);

        // Early s_last on element 3
        run_load(8, 2, 0, 4'h0, -1, 1'b0);
        check("early_err", err, 1'b1);
        check("early_wr_cnt", wr_cnt, 8);
        check("early_mem7", mem[7], 8);
        repeat (3) @(posedge clk);
        #1;
        check("early_err_sticky", err, 1'b1);

        // length 0: also clears err
        run_load(0, -1, 0, 4'h0, -1, 1'b0);
        check("zero_done_cnt", done_cnt, 1);
        check("zero_wr_cnt", wr_cnt, 0);
        check("zero_err", err, 1'b0);
        check("zero_trace_len", tr_n, 1);

        // length LENGTH+1
        run_load(LEN + 1, -1, 0, 4'h0, -1, 1'b0);
        check("over_err", err, 1'b1);
        check("over_done_cnt", done_cnt, 1);
        check("over_wr_cnt", wr_cnt, 0);

        // start during FILL is ignored
        run_load(4, 3, 0, 4'h0, 1, 1'b0);
        check("restart_wr_cnt", wr_cnt, 4);
        check("restart_done_cnt", done_cnt, 1);
        check("restart_mem3", mem[3], 4);
        check("restart_err", err, 1'b0);

        // Reset during ISSUE
        run_load(8, 7, 100, 4'h0, -1, 1'b1);
        check("rst_wr_cnt", wr_cnt, 0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_ctrl", {busy, done, err, cfg_en, bus.s_ready}, 5'b0);
        check("rst_cfg", {bus.cfg_valid, bus.cfg_write, bus.cfg_rready}, 12'h0);
        check("rst_addr", bus.cfg_addr, 40'h0);
        check("rst_data", bus.cfg_wdata, 128'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_load(4, 3, 0, 4'h0, -1, 1'b0);
        for (int k = 0; k < 4; k++) check($sformatf("post_rst_mem%0d", k), mem[k], k + 1);
        check("post_rst_wr_cnt", wr_cnt, 4);
        check("post_rst_done", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
